// File: rtl/count_sched_if.sv
// ----------------------------------------------------------------------------
// count_sched_if
// Purpose : groups the requester-side and status signals of count_sched.
// Signals :
//   req     [1:0] per-requester session request (held for the whole session)
//   x       [1:0] per-requester count-enable (only the owner's bit is used)
//   grant   [1:0] one-hot grant
//   q       [3:0] shared session count
//   busy          high in CLEAR and COUNT
//   done          one-cycle end-of-session pulse
//   done_id       requester whose session ended (valid with done)
//   full          session ended at q=15
//   timeout       session ended by the idle watchdog
// Modports: master = requester side / bench, slave = count_sched.
// ----------------------------------------------------------------------------
interface count_sched_if;
    logic [1:0] req;
    logic [1:0] x;
    logic [1:0] grant;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       full;
    logic       timeout;

    modport master (
        output req, x,
        input  grant, q, busy, done, done_id, full, timeout
    );

    modport slave (
        input  req, x,
        output grant, q, busy, done, done_id, full, timeout
    );
endinterface

// File: rtl/count_sched.sv
// ----------------------------------------------------------------------------
// count_sched
// Purpose : two-requester round-robin scheduler for a shared 4-bit counting
//           session. The granted requester increments q with its x bit until
//           q saturates at 15 or it releases req; done/done_id/full report
//           how the session ended.
// Ports   :
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset (aborts any session, no done)
//   bus    slave modport of count_sched_if (req, x in; grant, q, busy, done,
//          done_id, full, timeout out). All outputs are registered.
// Config  : define COUNT_SCHED_TIMEOUT_EN to add an 8-bit idle watchdog that
//           ends a session after 255 consecutive non-counting COUNT cycles
//           (timeout=1). Without it, timeout is tied low.
// ----------------------------------------------------------------------------
module count_sched (
    input  logic         clock,
    input  logic         reset,
    count_sched_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_CLEAR = 4'b0010,
        S_COUNT = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_last,  w_last_nxt;   // last-served requester (lowest priority)
    logic [3:0] r_q,     w_q_nxt;
    logic [1:0] r_grant, w_grant_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic       r_done_id, w_done_id_nxt;
    logic       r_full,  w_full_nxt;

    logic       w_winner;
    logic       w_req_own;
    logic       w_x_own;

`ifdef COUNT_SCHED_TIMEOUT_EN
    logic [7:0] r_idle,    w_idle_nxt;
    logic       r_timeout, w_timeout_nxt;
`endif

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req == 2'b11) begin
            w_winner = ~r_last;
        end else if (bus.req[1]) begin
            w_winner = 1'b1;
        end
    end

    assign w_req_own = bus.req[r_owner];
    assign w_x_own   = bus.x[r_owner];

    // Next-state and registered-output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_q_nxt       = r_q;
        w_grant_nxt   = r_grant;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_full_nxt    = 1'b0;
`ifdef COUNT_SCHED_TIMEOUT_EN
        w_idle_nxt    = r_idle;
        w_timeout_nxt = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (bus.req != 2'b00) begin
                    w_state_nxt = S_CLEAR;
                    w_owner_nxt = w_winner;
                    w_grant_nxt = w_winner ? 2'b10 : 2'b01;
                end
            end

            S_CLEAR: begin
                w_q_nxt     = '0;
`ifdef COUNT_SCHED_TIMEOUT_EN
                w_idle_nxt  = '0;
`endif
                w_state_nxt = S_COUNT;
            end

            S_COUNT: begin
                // Ending conditions are checked in priority order; a release
                // beats both saturation and a same-cycle increment.
                if (!w_req_own) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_owner;
                    w_grant_nxt   = '0;
                end else if (r_q == 4'd15) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_owner;
                    w_grant_nxt   = '0;
                    w_full_nxt    = 1'b1;
`ifdef COUNT_SCHED_TIMEOUT_EN
                end else if (r_idle == 8'd255) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_owner;
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
`endif
                end else if (w_x_own) begin
                    w_q_nxt       = r_q + 4'd1;
`ifdef COUNT_SCHED_TIMEOUT_EN
                    w_idle_nxt    = '0;
                end else begin
                    w_idle_nxt    = r_idle + 8'd1;
`endif
                end
            end

            S_DONE: begin
                w_last_nxt  = r_owner;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_COUNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;   // requester 0 has priority after reset
            r_q       <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_full    <= 1'b0;
`ifdef COUNT_SCHED_TIMEOUT_EN
            r_idle    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_q       <= w_q_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_full    <= w_full_nxt;
`ifdef COUNT_SCHED_TIMEOUT_EN
            r_idle    <= w_idle_nxt;
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign bus.grant   = r_grant;
    assign bus.q       = r_q;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.done_id = r_done_id;
    assign bus.full    = r_full;
`ifdef COUNT_SCHED_TIMEOUT_EN
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset, with ports named clock and reset as in the existing counter and control blocks.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 req  input  2  per-requester request for a counting session; held high for the whole session.
REQ-005 x  input  2  per-requester count-enable; only the granted requester's bit is used.
REQ-006 grant  output  2  one-hot grant; at most one bit high.
REQ-007 q  output  4  shared 4-bit session count.
REQ-008 busy  output  1  high in CLEAR and COUNT.
REQ-009 done  output  1  one-cycle pulse ending a session.
REQ-010 done_id  output  1  index of the requester whose session ended; valid while done=1.
REQ-011 full  output  1  high with done when the session ended at q=15.
REQ-012 timeout  output  1  high with done when the session ended by watchdog; constant 0 when the watchdog is compiled out.

Function
REQ-013 The controller SHALL be a one-hot FSM with states IDLE, CLEAR, COUNT and DONE.
REQ-014 In IDLE with req!=0, the winner SHALL be chosen round-robin, with the last-served requester at lowest priority; grant SHALL assert on the next edge together with entry to CLEAR.
REQ-015 In IDLE with req=0, the state SHALL remain IDLE and grant SHALL stay 0.
REQ-016 CLEAR SHALL last exactly one cycle, load q=0, and go to COUNT.
REQ-017 In COUNT, q SHALL increment by 1 on each edge where x[owner]=1 and q<15; q SHALL never wrap past 15.
REQ-018 In COUNT, when q=15, the next edge SHALL enter DONE with full=1.
REQ-019 In COUNT, when req[owner]=0, the next edge SHALL enter DONE with full=0, even if x[owner]=1; a release takes priority over an increment on the same cycle.
REQ-020 DONE SHALL last one cycle: done=1, done_id=owner, grant=0, q held, round-robin pointer updated; the next state SHALL be IDLE.
REQ-021 The non-owner's req and x SHALL be ignored until IDLE; a pending request SHALL be granted no earlier than 2 cycles after done.
REQ-022 With both requesters continuously requesting, grants SHALL alternate 0,1,0,1...
REQ-023 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-024 While reset=1 at a rising edge: state=IDLE, q=0, grant=0, busy=0, done=0, done_id=0, full=0, timeout=0, and the pointer gives requester 0 priority.
REQ-025 Reset asserted mid-session SHALL abort the session without a done pulse; reset SHALL take priority over all other inputs.

Configuration
REQ-026 Macro COUNT_SCHED_TIMEOUT_EN defined: an 8-bit idle counter SHALL clear on CLEAR and on every increment, and SHALL count COUNT-state cycles with x[owner]=0; at 255 the next edge SHALL enter DONE with timeout=1, full=0.
REQ-027 Macro COUNT_SCHED_TIMEOUT_EN undefined: there is no idle counter, timeout SHALL be tied to 0, and a session ends only by reaching q=15 or by release.

Verification
REQ-028 Reset, then req=01 with x=01 held: grant=01 1 cycle later; q counts 0..15 over 15 cycles; done=1, done_id=0, full=1 the cycle after q=15; q holds 15.
REQ-029 req=11 from reset, both x high, held 4 sessions: grant order 01,10,01,10; each done with full=1.
REQ-030 req=01, x[0] toggled 1,0 alternately: q increments only on x=1 cycles and reaches 15 after 30 COUNT cycles.
REQ-031 Requester 0 drops req at q=6 with x[0]=1: done=1, full=0, q=6, grant=00; requester 1 (pending) is granted 2 cycles later.
REQ-032 Reset pulsed at q=9: the next cycle shows q=0, grant=0, IDLE, no done pulse; req=10 afterwards is granted to requester 1.
REQ-033 With COUNT_SCHED_TIMEOUT_EN, req=01 with x=00: done with timeout=1 after 255 COUNT cycles and q=0; without the macro, no done after 1000 cycles.
